// File: rtl/tdd_pkg.sv
// Shared types and helpers for the TDD frame scheduler: FSM state encoding,
// length limits and the half-open window membership test.
package tdd_pkg;

    localparam int CNT_W_DEF = 24;
    localparam int MIN_FRAME = 2;
    // Window comparisons run at this width; positions are zero-extended into it.
    localparam int WIN_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // start < stop: plain range; start > stop: range wraps through 0;
    // start == stop: empty.
    function automatic logic in_window(
        input logic [WIN_W-1:0] pos,
        input logic [WIN_W-1:0] start,
        input logic [WIN_W-1:0] stop
    );
        logic hit;
        if (start < stop) begin
            hit = (pos >= start) && (pos < stop);
        end else if (start > stop) begin
            hit = (pos >= start) || (pos < stop);
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/tdd_window.sv
// Registered window comparator: hit follows pos by one clk and is held low
// whenever en is low.
module tdd_window #(
    parameter int CNT_W = tdd_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] pos,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] stop,
    output logic             hit
);
    import tdd_pkg::*;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit <= 1'b0;
        end else begin
            hit <= en && in_window(WIN_W'(pos), WIN_W'(start), WIN_W'(stop));
        end
    end

endmodule

// File: rtl/tdd_frame_scheduler.sv
// TDD frame scheduler: sample position counter, per-frame shadow config,
// one-shot length adjustment and the RX/TX gates derived from the windows.
//
//   state | meaning
//   IDLE  | stopped; position held at 0, gates closed
//   RUN   | counting samples on tick, gates follow windows or FDD mode
module tdd_frame_scheduler #(
    parameter int CNT_W = tdd_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic             tddmode,
    input  logic [CNT_W-1:0] frame_len,
    input  logic [CNT_W-1:0] frame_adj,
    input  logic             adj_req,
    input  logic [CNT_W-1:0] tstart,
    input  logic [CNT_W-1:0] tend,
    input  logic [CNT_W-1:0] rstart,
    input  logic [CNT_W-1:0] rend,
    output logic             sys_ien,
    output logic             sys_oen,
    output logic             tx_rx,
    output logic             frame_sync,
    output logic [31:0]      frame_cnt,
    output logic [CNT_W-1:0] sample_pos,
    output logic             adj_pending
);
    import tdd_pkg::*;

    // Two extra bits so the largest length plus the largest positive
    // correction cannot wrap into the sign bit.
    localparam int SUM_W = CNT_W + 2;

    state_t           state_q, state_d;
    logic [CNT_W:0]   len_eff_q;
    logic [CNT_W:0]   len_next;
    logic [CNT_W-1:0] tstart_q, tend_q, rstart_q, rend_q;
    logic [CNT_W-1:0] adj_val_q;
    logic [CNT_W-1:0] adj_use;
    logic [SUM_W-1:0] len_base, len_sum;
    logic             frame_start, at_last;
    logic             gate_en, gate_en_q, tdd_q;
    logic             tx_hit, rx_hit;

    assign at_last = ({1'b0, sample_pos} == (len_eff_q - {{CNT_W{1'b0}}, 1'b1}));

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        gate_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d     = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    gate_en = 1'b1;
                    if (tick && at_last) begin
                        frame_start = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Length of the frame about to start; a pending adjustment is consumed by it.
    always_comb begin
        adj_use  = adj_pending ? adj_val_q : '0;
        len_base = (frame_len < CNT_W'(MIN_FRAME)) ? SUM_W'(MIN_FRAME) : SUM_W'(frame_len);
        len_sum  = len_base + {{2{adj_use[CNT_W-1]}}, adj_use};
        if (len_sum[SUM_W-1] || (len_sum < SUM_W'(MIN_FRAME))) begin
            len_next = (CNT_W+1)'(MIN_FRAME);
        end else begin
            len_next = len_sum[CNT_W:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sample_pos  <= '0;
            frame_cnt   <= '0;
            frame_sync  <= 1'b0;
            adj_pending <= 1'b0;
            adj_val_q   <= '0;
            len_eff_q   <= (CNT_W+1)'(MIN_FRAME);
            tstart_q    <= '0;
            tend_q      <= '0;
            rstart_q    <= '0;
            rend_q      <= '0;
            gate_en_q   <= 1'b0;
            tdd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_sync <= frame_start;
            gate_en_q  <= gate_en;
            tdd_q      <= tddmode;

            if (frame_start) begin
                sample_pos <= '0;
                frame_cnt  <= frame_cnt + 32'd1;
                len_eff_q  <= len_next;
                tstart_q   <= tstart;
                tend_q     <= tend;
                rstart_q   <= rstart;
                rend_q     <= rend;
            end else if (state_d == IDLE) begin
                sample_pos <= '0;
            end else if (tick) begin
                sample_pos <= sample_pos + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            // A request landing on a frame start is kept for the following frame.
            if (adj_req) begin
                adj_val_q   <= frame_adj;
                adj_pending <= 1'b1;
            end else if (frame_start) begin
                adj_pending <= 1'b0;
            end
        end
    end

    tdd_window #(.CNT_W(CNT_W)) u_tx_win (
        .clk   (clk),
        .rst   (rst),
        .en    (gate_en),
        .pos   (sample_pos),
        .start (tstart_q),
        .stop  (tend_q),
        .hit   (tx_hit)
    );

    tdd_window #(.CNT_W(CNT_W)) u_rx_win (
        .clk   (clk),
        .rst   (rst),
        .en    (gate_en),
        .pos   (sample_pos),
        .start (rstart_q),
        .stop  (rend_q),
        .hit   (rx_hit)
    );

    // TX wins where the windows overlap; FDD opens both gates while running.
    assign sys_oen = gate_en_q & (~tdd_q | tx_hit);
    assign sys_ien = gate_en_q & (~tdd_q | (rx_hit & ~tx_hit));
    assign tx_rx   = gate_en_q & tdd_q & tx_hit;

endmodule

// File: tb/tb_tdd_frame_scheduler.sv
// Scoreboard bench: stimulus pushes one expected record per frame_sync, the
// monitor accumulates per-frame gate masks and compares at each frame_sync.
module tb_tdd_frame_scheduler;

    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst, en, tick, tddmode, adj_req;
    logic [CW-1:0] frame_len, frame_adj, tstart, tend, rstart, rend;
    logic          sys_ien, sys_oen, tx_rx, frame_sync, adj_pending;
    logic [31:0]   frame_cnt;
    logic [CW-1:0] sample_pos;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cnt;
        bit          pend;
        bit          pv;
        int unsigned len;
        logic [15:0] oen;
        logic [15:0] ien;
        logic [15:0] txrx;
    } exp_t;

    exp_t sbq[$];

    tdd_frame_scheduler #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .tick        (tick),
        .tddmode     (tddmode),
        .frame_len   (frame_len),
        .frame_adj   (frame_adj),
        .adj_req     (adj_req),
        .tstart      (tstart),
        .tend        (tend),
        .rstart      (rstart),
        .rend        (rend),
        .sys_ien     (sys_ien),
        .sys_oen     (sys_oen),
        .tx_rx       (tx_rx),
        .frame_sync  (frame_sync),
        .frame_cnt   (frame_cnt),
        .sample_pos  (sample_pos),
        .adj_pending (adj_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int unsigned cnt, input bit pend, input bit pv, input int unsigned len,
                        input logic [15:0] oen, input logic [15:0] ien, input logic [15:0] txrx);
        exp_t e;
        e.cnt = cnt; e.pend = pend; e.pv = pv; e.len = len;
        e.oen = oen; e.ien = ien; e.txrx = txrx;
        sbq.push_back(e);
    endtask

    task automatic wait_sync(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            do begin
                @(posedge clk);
                #1;
                t++;
            end while (!frame_sync && t < 40);
            chk("sync_arrived", {31'd0, frame_sync}, 32'd1);
        end
    endtask

    // Monitor: the gate seen in a clk belongs to the position of the previous clk.
    logic [15:0]   acc_oen, acc_ien, acc_txrx;
    logic [CW-1:0] prev_pos;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            acc_oen  = '0;
            acc_ien  = '0;
            acc_txrx = '0;
            prev_pos = '0;
        end else begin
            if (sys_oen) acc_oen[prev_pos[3:0]]  = 1'b1;
            if (sys_ien) acc_ien[prev_pos[3:0]]  = 1'b1;
            if (tx_rx)   acc_txrx[prev_pos[3:0]] = 1'b1;
            if (frame_sync) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got frame_sync with cnt %0d, expected none", frame_cnt);
                end else begin
                    e = sbq.pop_front();
                    chk("frame_cnt", frame_cnt, e.cnt);
                    chk("adj_pending_at_sync", {31'd0, adj_pending}, {31'd0, e.pend});
                    if (e.pv) begin
                        chk("frame_len", 32'(prev_pos) + 32'd1, e.len);
                        chk("oen_mask", {16'd0, acc_oen}, {16'd0, e.oen});
                        chk("ien_mask", {16'd0, acc_ien}, {16'd0, e.ien});
                        chk("txrx_mask", {16'd0, acc_txrx}, {16'd0, e.txrx});
                    end
                end
                acc_oen  = '0;
                acc_ien  = '0;
                acc_txrx = '0;
            end
            prev_pos = sample_pos;
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; tick = 1'b1; tddmode = 1'b1; adj_req = 1'b0;
        frame_len = 24'd10; frame_adj = '0;
        tstart = 24'd2; tend = 24'd5; rstart = 24'd6; rend = 24'd9;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_oen", {31'd0, sys_oen}, 32'd0);
        chk("rst_ien", {31'd0, sys_ien}, 32'd0);
        chk("rst_txrx", {31'd0, tx_rx}, 32'd0);
        chk("rst_sync", {31'd0, frame_sync}, 32'd0);
        chk("rst_cnt", frame_cnt, 32'd0);
        chk("rst_pos", 32'(sample_pos), 32'd0);
        chk("rst_pend", {31'd0, adj_pending}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic TX [2,5) / RX [6,9), length 10
        push(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        push(2, 0, 1, 10, 16'h001C, 16'h01C0, 16'h001C);
        push(3, 0, 1, 10, 16'h001C, 16'h01C0, 16'h001C);
        @(negedge clk);
        en = 1'b1;
        wait_sync(3);

        // Wrapping TX [8,2), empty RX [3,3)
        @(negedge clk);
        tstart = 24'd8; tend = 24'd2; rstart = 24'd3; rend = 24'd3;
        push(4, 0, 1, 10, 16'h001C, 16'h01C0, 16'h001C);
        push(5, 0, 1, 10, 16'h0303, 16'h0000, 16'h0303);
        wait_sync(2);

        // Empty TX [3,3), wrapping RX [8,2)
        @(negedge clk);
        tstart = 24'd3; tend = 24'd3; rstart = 24'd8; rend = 24'd2;
        push(6, 0, 1, 10, 16'h0303, 16'h0000, 16'h0303);
        push(7, 0, 1, 10, 16'h0000, 16'h0303, 16'h0000);
        wait_sync(2);

        // Overlap: TX [2,6), RX [4,8) -> RX only on 6,7
        @(negedge clk);
        tstart = 24'd2; tend = 24'd6; rstart = 24'd4; rend = 24'd8;
        push(8, 0, 1, 10, 16'h0000, 16'h0303, 16'h0000);
        push(9, 0, 1, 10, 16'h003C, 16'h00C0, 16'h003C);
        wait_sync(2);

        // Adjustment -3 mid-frame: next frame 7, then 10
        repeat (3) @(negedge clk);
        frame_adj = 24'hFFFFFD;
        adj_req = 1'b1;
        @(negedge clk);
        adj_req = 1'b0;
        chk("pend_after_req", {31'd0, adj_pending}, 32'd1);
        push(10, 0, 1, 10, 16'h003C, 16'h00C0, 16'h003C);
        push(11, 0, 1, 7, 16'h003C, 16'h0040, 16'h003C);
        push(12, 0, 1, 10, 16'h003C, 16'h00C0, 16'h003C);
        wait_sync(3);

        // Adjustment -20 clamps to a 2-sample frame
        repeat (2) @(negedge clk);
        frame_adj = 24'hFFFFEC;
        adj_req = 1'b1;
        @(negedge clk);
        adj_req = 1'b0;
        push(13, 0, 1, 10, 16'h003C, 16'h00C0, 16'h003C);
        push(14, 0, 1, 2, 16'h0000, 16'h0000, 16'h0000);
        push(15, 0, 1, 10, 16'h003C, 16'h00C0, 16'h003C);
        wait_sync(3);

        // frame_len 6 written mid-frame: current frame still 10
        repeat (2) @(negedge clk);
        frame_len = 24'd6;
        push(16, 0, 1, 10, 16'h003C, 16'h00C0, 16'h003C);
        push(17, 0, 1, 6, 16'h003C, 16'h0000, 16'h003C);
        wait_sync(2);

        // tick held low freezes the position
        repeat (2) @(negedge clk);
        tick = 1'b0;
        repeat (5) @(negedge clk);
        chk("pos_frozen", 32'(sample_pos), 32'd1);
        tick = 1'b1;
        push(18, 0, 1, 6, 16'h003C, 16'h0000, 16'h003C);
        wait_sync(1);

        // Drop en at position 2: gates close on the next clk, count held
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_oen", {31'd0, sys_oen}, 32'd0);
        chk("drop_ien", {31'd0, sys_ien}, 32'd0);
        chk("drop_txrx", {31'd0, tx_rx}, 32'd0);
        chk("drop_pos", 32'(sample_pos), 32'd0);
        chk("drop_cnt", frame_cnt, 32'd18);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_cnt_held", frame_cnt, 32'd18);

        // FDD: both gates open, tx_rx low
        @(negedge clk);
        tddmode = 1'b0;
        push(19, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        push(20, 0, 1, 6, 16'h003F, 16'h003F, 16'h0000);
        push(21, 0, 1, 6, 16'h003F, 16'h003F, 16'h0000);
        @(negedge clk);
        en = 1'b1;
        wait_sync(3);

        // Reset mid-frame with en still high
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_oen", {31'd0, sys_oen}, 32'd0);
        chk("rst2_ien", {31'd0, sys_ien}, 32'd0);
        chk("rst2_cnt", frame_cnt, 32'd0);
        chk("rst2_pos", 32'(sample_pos), 32'd0);
        push(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        wait_sync(1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
